// File: rtl/rx_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rx_cmd_pkg
// Purpose  : Shared opcodes, operand addresses and FSM state encoding for
//            the UART receive command decoder.
// Revision : 1.0 - initial release
// ============================================================================
package rx_cmd_pkg;

  // Command opcodes (first byte of every frame)
  localparam logic [7:0] OP_WRITE   = 8'hAA;
  localparam logic [7:0] OP_READ    = 8'hBB;
  localparam logic [7:0] OP_ALU_OPS = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;

  // Register-file locations that hold the ALU operands
  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WR_ADDR  = 4'd1,
    S_WR_DATA  = 4'd2,
    S_RD_ADDR  = 4'd3,
    S_RD_WAIT  = 4'd4,
    S_ALU_A    = 4'd5,
    S_ALU_B    = 4'd6,
    S_ALU_FUN  = 4'd7,
    S_ALU_WAIT = 4'd8,
    S_TX_LO    = 4'd9,
    S_TX_HI    = 4'd10
  } state_t;

  // States that are waiting for the next byte of a frame
  function automatic logic is_collect_state(input state_t s);
    return (s == S_WR_ADDR) || (s == S_WR_DATA) || (s == S_RD_ADDR) ||
           (s == S_ALU_A)   || (s == S_ALU_B)   || (s == S_ALU_FUN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_cmd_timer.sv
`default_nettype none
// ============================================================================
// Module   : rx_cmd_timer
// Purpose  : Inter-byte timeout counter. Clears on every received byte and
//            whenever counting is disabled; flags expiry on the last cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rx_cmd_timer #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] cnt;

  // Count idle cycles while a frame is incomplete
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (clear || !count_en) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th silent cycle so the decoder leaves on that edge
  assign expired = count_en && !clear && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/rx_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : rx_cmd_decoder
// Purpose  : Parses framed commands (write / read / ALU with and without
//            operands) from UART receive bytes, drives register-file and ALU
//            strobes, and returns results byte-wise over valid/ready.
// Config   : RX_CMD_TIMEOUT_EN enables the inter-byte timeout (rx_cmd_timer).
// Revision : 1.0 - initial release
// ============================================================================
module rx_cmd_decoder
  import rx_cmd_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 4,
  parameter int FUN_W          = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [DATA_W-1:0]   RX_P_DATA,
  input  logic                RX_D_VLD,
  input  logic [DATA_W-1:0]   RdData,
  input  logic                RdData_Valid,
  input  logic [2*DATA_W-1:0] ALU_OUT,
  input  logic                OUT_Valid,
  input  logic                TX_READY,
  output logic                WrEn,
  output logic                RdEn,
  output logic [ADDR_W-1:0]   Address,
  output logic [DATA_W-1:0]   WrData,
  output logic                ALU_EN,
  output logic [FUN_W-1:0]    ALU_FUN,
  output logic [DATA_W-1:0]   TX_DATA,
  output logic                TX_VALID,
  output logic                CMD_ERR
);

  state_t              state;
  logic                is_alu;   // result being sent has a high byte
  logic [DATA_W-1:0]   hi_byte;  // ALU result high byte waiting for TX_HI
  logic                timeout_hit;

`ifdef RX_CMD_TIMEOUT_EN
  logic collecting;
  assign collecting = is_collect_state(state);

  rx_cmd_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (RX_D_VLD),
    .count_en (collecting),
    .expired  (timeout_hit)
  );
`else
  // Timeout compiled out: constant 0, parameter kept referenced
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  // Command FSM with registered strobes, result path and error pulse
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      is_alu   <= 1'b0;
      hi_byte  <= '0;
      WrEn     <= 1'b0;
      RdEn     <= 1'b0;
      Address  <= '0;
      WrData   <= '0;
      ALU_EN   <= 1'b0;
      ALU_FUN  <= '0;
      TX_DATA  <= '0;
      TX_VALID <= 1'b0;
      CMD_ERR  <= 1'b0;
    end else begin
      WrEn    <= 1'b0;
      RdEn    <= 1'b0;
      ALU_EN  <= 1'b0;
      CMD_ERR <= 1'b0;

      if (timeout_hit) begin
        state   <= S_IDLE;
        CMD_ERR <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (RX_D_VLD) begin
              case (RX_P_DATA)
                OP_WRITE:   state <= S_WR_ADDR;
                OP_READ:    state <= S_RD_ADDR;
                OP_ALU_OPS: state <= S_ALU_A;
                OP_ALU_NOP: state <= S_ALU_FUN;
                default:    CMD_ERR <= 1'b1;
              endcase
            end
          end
          S_WR_ADDR: begin
            if (RX_D_VLD) begin
              Address <= RX_P_DATA[ADDR_W-1:0];
              state   <= S_WR_DATA;
            end
          end
          S_WR_DATA: begin
            if (RX_D_VLD) begin
              WrData <= RX_P_DATA;
              WrEn   <= 1'b1;
              state  <= S_IDLE;
            end
          end
          S_RD_ADDR: begin
            if (RX_D_VLD) begin
              Address <= RX_P_DATA[ADDR_W-1:0];
              RdEn    <= 1'b1;
              state   <= S_RD_WAIT;
            end
          end
          S_RD_WAIT: begin
            if (RX_D_VLD) CMD_ERR <= 1'b1;
            if (RdData_Valid) begin
              TX_DATA  <= RdData;
              TX_VALID <= 1'b1;
              is_alu   <= 1'b0;
              state    <= S_TX_LO;
            end
          end
          S_ALU_A: begin
            if (RX_D_VLD) begin
              Address <= ADDR_W'(OPA_ADDR);
              WrData  <= RX_P_DATA;
              WrEn    <= 1'b1;
              state   <= S_ALU_B;
            end
          end
          S_ALU_B: begin
            if (RX_D_VLD) begin
              Address <= ADDR_W'(OPB_ADDR);
              WrData  <= RX_P_DATA;
              WrEn    <= 1'b1;
              state   <= S_ALU_FUN;
            end
          end
          S_ALU_FUN: begin
            if (RX_D_VLD) begin
              ALU_FUN <= RX_P_DATA[FUN_W-1:0];
              ALU_EN  <= 1'b1;
              state   <= S_ALU_WAIT;
            end
          end
          S_ALU_WAIT: begin
            if (RX_D_VLD) CMD_ERR <= 1'b1;
            if (OUT_Valid) begin
              TX_DATA  <= ALU_OUT[DATA_W-1:0];
              hi_byte  <= ALU_OUT[2*DATA_W-1:DATA_W];
              TX_VALID <= 1'b1;
              is_alu   <= 1'b1;
              state    <= S_TX_LO;
            end
          end
          S_TX_LO: begin
            // TX_VALID is already high here, so READY alone completes the transfer
            if (RX_D_VLD) CMD_ERR <= 1'b1;
            if (TX_READY) begin
              if (is_alu) begin
                TX_DATA <= hi_byte;
                state   <= S_TX_HI;
              end else begin
                TX_VALID <= 1'b0;
                state    <= S_IDLE;
              end
            end
          end
          S_TX_HI: begin
            if (RX_D_VLD) CMD_ERR <= 1'b1;
            if (TX_READY) begin
              TX_VALID <= 1'b0;
              state    <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_cmd_decoder
// Purpose  : Self-checking bench for rx_cmd_decoder. Expected strobes,
//            transmitted bytes and error pulses are queued as stimulus is
//            driven and matched in order against what the decoder produces.
// Config   : timeout steps run only when RX_CMD_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_cmd_decoder;

  localparam int EV_WR  = 1;
  localparam int EV_RD  = 2;
  localparam int EV_ALU = 3;
  localparam int EV_TX  = 4;
  localparam int EV_ERR = 5;

  typedef struct {
    int          kind;
    logic [15:0] a;
    logic [15:0] b;
  } ev_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic [7:0]  RdData = '0;
  logic        RdData_Valid = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        OUT_Valid = 1'b0;
  logic        TX_READY = 1'b0;
  logic        WrEn, RdEn, ALU_EN, TX_VALID, CMD_ERR;
  logic [3:0]  Address, ALU_FUN;
  logic [7:0]  WrData, TX_DATA;

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  rx_cmd_decoder #(
    .DATA_W(8), .ADDR_W(4), .FUN_W(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_OUT(ALU_OUT),
    .OUT_Valid(OUT_Valid), .TX_READY(TX_READY), .WrEn(WrEn), .RdEn(RdEn),
    .Address(Address), .WrData(WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input logic [15:0] a, input logic [15:0] b);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b;
    exp_q.push_back(e);
  endtask

  // Observed event matched against the oldest expectation
  task automatic match(input int kind, input logic [15:0] a, input logic [15:0] b);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("spurious_event_kind", kind, 0);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_a", a, e.a);
      check("event_b", b, e.b);
    end
  endtask

  // Monitor samples on the falling edge, away from the active edge
  always @(negedge CLK) begin
    if (RST) begin
      if (WrEn)                 match(EV_WR,  16'(Address), 16'(WrData));
      if (RdEn)                 match(EV_RD,  16'(Address), 16'h0);
      if (ALU_EN)               match(EV_ALU, 16'(ALU_FUN), 16'h0);
      if (TX_VALID && TX_READY) match(EV_TX,  16'(TX_DATA), 16'h0);
      if (CMD_ERR)              match(EV_ERR, 16'h0,        16'h0);
    end
  end

  // All tasks below start and end at posedge + 1
  task automatic rx(input logic [7:0] b);
    RX_P_DATA = b; RX_D_VLD = 1'b1;
    @(posedge CLK); #1;
    RX_D_VLD = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic rd_resp(input logic [7:0] d);
    RdData = d; RdData_Valid = 1'b1;
    @(posedge CLK); #1;
    RdData_Valid = 1'b0;
  endtask

  task automatic alu_resp(input logic [15:0] d);
    ALU_OUT = d; OUT_Valid = 1'b1;
    @(posedge CLK); #1;
    OUT_Valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    check("reset_outputs", {WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, TX_DATA, TX_VALID, CMD_ERR}, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b1;
    idle(2);

    // Register write
    push(EV_WR, 16'h5, 16'h3C);
    rx(8'hAA); rx(8'h05); rx(8'h3C);
    idle(3);
    check("write_addr_held", Address, 4'h5);
    check("write_data_held", WrData, 8'h3C);

    // Upper address bits ignored
    push(EV_WR, 16'h3, 16'h81);
    rx(8'hAA); rx(8'hA3); rx(8'h81);
    idle(2);

    // Read with back-pressure: TX_DATA stable while READY low
    push(EV_RD, 16'h7, 16'h0);
    rx(8'hBB); rx(8'h07);
    idle(2);
    push(EV_TX, 16'h5A, 16'h0);
    rd_resp(8'h5A);
    for (int i = 0; i < 3; i++) begin
      check("rd_tx_valid_held", TX_VALID, 1'b1);
      check("rd_tx_data_held", TX_DATA, 8'h5A);
      idle(1);
    end
    TX_READY = 1'b1;
    idle(1);
    TX_READY = 1'b0;
    check("rd_single_byte", TX_VALID, 1'b0);
    idle(2);

    // Stray result pulses outside wait states are ignored
    TX_READY = 1'b1;
    rd_resp(8'h11);
    alu_resp(16'h2222);
    idle(2);
    check("stray_no_tx", TX_VALID, 1'b0);
    TX_READY = 1'b0;

    // ALU with operands
    push(EV_WR, 16'h0, 16'h10);
    push(EV_WR, 16'h1, 16'h20);
    push(EV_ALU, 16'h1, 16'h0);
    rx(8'hCC); rx(8'h10); rx(8'h20); rx(8'h01);
    idle(2);
    push(EV_TX, 16'h34, 16'h0);
    push(EV_TX, 16'h12, 16'h0);
    TX_READY = 1'b1;
    alu_resp(16'h1234);
    idle(4);
    TX_READY = 1'b0;
    check("alu_tx_done", TX_VALID, 1'b0);

    // ALU without operands, function byte truncated to 4 bits
    push(EV_ALU, 16'h9, 16'h0);
    rx(8'hDD); rx(8'hF9);
    idle(1);
    push(EV_TX, 16'hEF, 16'h0);
    push(EV_TX, 16'hBE, 16'h0);
    alu_resp(16'hBEEF);
    idle(2);
    check("alu_hi_wait_valid", TX_VALID, 1'b1);
    check("alu_lo_held", TX_DATA, 8'hEF);
    TX_READY = 1'b1;
    idle(1);
    TX_READY = 1'b0;
    check("alu_hi_presented", TX_DATA, 8'hBE);
    idle(2);
    check("alu_hi_held", TX_DATA, 8'hBE);
    TX_READY = 1'b1;
    idle(1);
    TX_READY = 1'b0;
    idle(1);

    // Bad opcode
    push(EV_ERR, 16'h0, 16'h0);
    rx(8'h55);
    idle(2);

    // Overrun during RD_WAIT, read still completes
    push(EV_RD, 16'h2, 16'h0);
    rx(8'hBB); rx(8'h02);
    push(EV_ERR, 16'h0, 16'h0);
    rx(8'h77);
    idle(1);
    push(EV_TX, 16'hC3, 16'h0);
    TX_READY = 1'b1;
    rd_resp(8'hC3);
    idle(3);
    TX_READY = 1'b0;

    // Reset while waiting on the ALU
    push(EV_ALU, 16'h2, 16'h0);
    rx(8'hDD); rx(8'h02);
    idle(1);
    RST = 1'b0;
    #1;
    check("reset_abort_outputs", {WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, TX_DATA, TX_VALID, CMD_ERR}, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b1;
    idle(1);
    TX_READY = 1'b1;
    alu_resp(16'h5678);
    idle(2);
    check("post_reset_no_tx", TX_VALID, 1'b0);
    TX_READY = 1'b0;
    push(EV_WR, 16'h1, 16'hFF);
    rx(8'hAA); rx(8'h01); rx(8'hFF);
    idle(2);

`ifdef RX_CMD_TIMEOUT_EN
    // Inter-byte timeout abandons a write
    push(EV_ERR, 16'h0, 16'h0);
    rx(8'hAA);
    idle(14);
    check("timeout_not_early", CMD_ERR, 1'b0);
    idle(6);
    push(EV_WR, 16'h1, 16'hFF);
    rx(8'hAA); rx(8'h01); rx(8'hFF);
    idle(2);
`endif

    idle(2);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_cmd_decoder.md
# rx_cmd_decoder

Byte-level command decoder directly downstream of the UART receiver. Consumes each validated parallel byte (`RX_P_DATA` qualified by the receiver's one-cycle `DATA_VALID` pulse) and parses framed commands:
- register write
- register read
- ALU operation with operands
- ALU operation without operands

It drives the register-file and ALU strobes and returns results as bytes over a valid/ready handshake to the UART transmit path.

## Interface
- `DATA_W`, 8 — byte width of UART payload, register data and ALU operands
- `ADDR_W`, 4 — register-file address width; low `ADDR_W` bits of the address byte are used, the rest are ignored
- `FUN_W`, 4 — ALU function width; low `FUN_W` bits of the function byte are used
- `TIMEOUT_CYCLES`, 65535 — inter-byte timeout in `CLK` cycles; used only when `RX_CMD_TIMEOUT_EN` is defined

Ports:
- `CLK` in 1 — single clock
- `RST` in 1 — asynchronous, active-low reset
- `RX_P_DATA` in `DATA_W` — received byte
- `RX_D_VLD` in 1 — one-cycle pulse, `RX_P_DATA` valid
- `RdData` in `DATA_W` — register-file read data
- `RdData_Valid` in 1 — read data valid pulse
- `ALU_OUT` in `2*DATA_W` — ALU result
- `OUT_Valid` in 1 — ALU result valid pulse
- `TX_READY` in 1 — transmitter accepts a byte
- `WrEn` out 1 — register write strobe
- `RdEn` out 1 — register read strobe
- `Address` out `ADDR_W` — register address
- `WrData` out `DATA_W` — register write data
- `ALU_EN` out 1 — ALU start strobe
- `ALU_FUN` out `FUN_W` — ALU function
- `TX_DATA` out `DATA_W` — byte to transmit
- `TX_VALID` out 1 — `TX_DATA` valid
- `CMD_ERR` out 1 — one-cycle error pulse

## Operation
- Opcodes:
  - `0xAA` write: ADDR, DATA
  - `0xBB` read: ADDR
  - `0xCC` ALU with operands: A, B, FUN
  - `0xDD` ALU without operands: FUN
- States: `IDLE`, `WR_ADDR`, `WR_DATA`, `RD_ADDR`, `RD_WAIT`, `ALU_A`, `ALU_B`, `ALU_FUN`, `ALU_WAIT`, `TX_LO`, `TX_HI`.
- `IDLE`, byte on `RX_D_VLD`:
  - `0xAA` → `WR_ADDR`
  - `0xBB` → `RD_ADDR`
  - `0xCC` → `ALU_A`
  - `0xDD` → `ALU_FUN`
  - any other value → `CMD_ERR` pulse, stay in `IDLE`.
- `WR_ADDR`: latch `Address` → `WR_DATA`.
- `WR_DATA`: latch `WrData`, pulse `WrEn` → `IDLE`.
- `RD_ADDR`: latch `Address`, pulse `RdEn` → `RD_WAIT`.
- `RD_WAIT`: on `RdData_Valid`, latch `RdData` into `TX_DATA` → `TX_LO`. Read returns exactly one byte.
- `ALU_A`: write byte to address 0 (`Address`=0, `WrData`=byte, `WrEn` pulse) → `ALU_B`.
- `ALU_B`: same to address 1 → `ALU_FUN`.
- `ALU_FUN`: latch `ALU_FUN`, pulse `ALU_EN` → `ALU_WAIT`.
- `ALU_WAIT`: on `OUT_Valid`, latch `ALU_OUT` into `TX_DATA` → `TX_LO`.
- `TX_LO`: `TX_VALID`=1 with the low byte held stable until `TX_READY`=1.
  - Read result → `IDLE`.
  - ALU result → `TX_HI`.
- `TX_HI`: high byte, same handshake → `IDLE`.
- Overrun: `RX_D_VLD` in `RD_WAIT`, `ALU_WAIT`, `TX_LO` or `TX_HI` → byte dropped, `CMD_ERR` pulse, state unchanged.
- `RdData_Valid` / `OUT_Valid` outside their wait state → ignored.

## Timing
- All outputs are registered. Reset value of every output is 0; state resets to `IDLE`.
- Strobes: `WrEn`, `RdEn` and `ALU_EN` are high for exactly one cycle, in the cycle after the `RX_D_VLD` that completed them. `Address`, `WrData` and `ALU_FUN` are valid in that cycle and held until next updated.
- Result to transmit: `TX_VALID` rises the cycle after `RdData_Valid` / `OUT_Valid`.
- Handshake:
  - A byte transfers on a cycle with `TX_VALID` and `TX_READY` both high.
  - `TX_VALID` drops, or the next byte is presented, the following cycle.
  - `TX_DATA` must not change while `TX_VALID`=1 and `TX_READY`=0.
- `CMD_ERR` pulses for one cycle, the cycle after the offending event.
- Reset asserted mid-command aborts immediately; no partial strobe is issued.

## Configuration
- `RX_CMD_TIMEOUT_EN` defined:
  - A counter clears on every `RX_D_VLD` and counts while in `WR_ADDR`, `WR_DATA`, `RD_ADDR`, `ALU_A`, `ALU_B` or `ALU_FUN`.
  - Reaching `TIMEOUT_CYCLES` → `IDLE` plus a `CMD_ERR` pulse.
  - Wait and TX states never time out.
- Not defined: no counter; collection states wait indefinitely for the next byte.

## Structure
- Package `rx_cmd_pkg`:
  - opcode constants `0xAA`/`0xBB`/`0xCC`/`0xDD`
  - state encoding
  - operand addresses A=0, B=1
- Sub-module `rx_cmd_timer` holds the timeout counter, instantiated only under `RX_CMD_TIMEOUT_EN`.

## Test plan
- Write: bytes `0xAA`,`0x05`,`0x3C` → single `WrEn` pulse with `Address`=5, `WrData`=`0x3C`; `CMD_ERR` stays 0.
- Read: `0xBB`,`0x07` → `RdEn` pulse with `Address`=7; `RdData`=`0x5A` with `RdData_Valid` → `TX_DATA`=`0x5A`, `TX_VALID` held through 3 cycles of `TX_READY`=0, then one transfer.
- ALU with operands: `0xCC`,`0x10`,`0x20`,`0x01`:
  - `WrEn` pulses to addresses 0 and 1 with data `0x10` and `0x20`
  - `ALU_EN` pulse with `ALU_FUN`=1
  - `ALU_OUT`=`0x1234` → transmits `0x34` then `0x12`.
- Error: opcode `0x55` → `CMD_ERR` pulse, `IDLE`; extra byte during `RD_WAIT` → `CMD_ERR` pulse, read still completes.
- Timeout (macro on, `TIMEOUT_CYCLES`=16): `0xAA` then silence → `CMD_ERR` pulse after 16 cycles, no `WrEn`; the next `0xAA`,`0x01`,`0xFF` writes normally.
- Reset asserted in `ALU_WAIT` → all outputs 0, state `IDLE`, a subsequent `OUT_Valid` is ignored.
